spi_regfile_rw: RTL and testbench
=================================

# spi_regfile_rw

Parametrised SPI slave register file with write and read-back, clocked entirely in the system clock domain. It replaces the write-only SPI register block feeding the PWM peripheral. It adds a configurable register count and width, a CIPO read path, frame-length checking and a per-write strobe. It sits between the `ui_in` SPI pins and the peripherals that consume `regs_out`.

## Interface
- `NUM_REGS`, default 8: number of registers implemented, at addresses 0..NUM_REGS-1.
- `ADDR_W`, default 7: address field width; NUM_REGS ≤ 2^ADDR_W.
- `DATA_W`, default 8: register and data field width.
- `RESET_VAL`, default 0: reset value of every register, DATA_W bits.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `SCLK` in 1: SPI clock, asynchronous to `clk`.
- `COPI` in 1: SPI controller-out data.
- `nCS` in 1: SPI chip select, active-low.
- `CIPO` out 1: SPI peripheral-out data.
- `cipo_oe` out 1: CIPO output enable; equals synchronised nCS inverted.
- `regs_out` out NUM_REGS*DATA_W: flattened registers; reg i occupies bits [i*DATA_W +: DATA_W].
- `wr_strobe` out 1: one-cycle pulse on each committed write.
- `wr_addr` out ADDR_W: address of the last committed write.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame format: FRAME_LEN = 1+ADDR_W+DATA_W bits, MSB first, SPI mode 0.
  - Bit 0 is R/W, where 1 = write.
  - The next ADDR_W bits are the address.
  - The last DATA_W bits are the data.
- `SCLK`, `COPI` and `nCS` each pass through a 2-FF synchroniser. A third register holds the previous value of each, for edge detection.
- COPI is sampled into the shift register on the detected SCLK rising edge. CIPO updates on the detected SCLK falling edge.
- Bit counter has width clog2(FRAME_LEN+1). It counts SCLK rising edges while in ACTIVE.
- FSM states:
  - IDLE: wait for synced nCS = 0, then clear the counter and shift register and go to ACTIVE.
  - ACTIVE: shift bits in.
    - The 17th (FRAME_LEN+1) rising edge is an overrun: pulse `frame_err`, go to DRAIN.
    - Synced nCS rising edge goes to IDLE and runs commit evaluation.
  - DRAIN: ignore SCLK and COPI; go to IDLE on synced nCS = 1.
- Read path: on the rising edge that completes the address field (count = 1+ADDR_W), if R/W = 0:
  - Load the output shifter with reg[addr], or all zeros if addr ≥ NUM_REGS.
  - Each following falling edge presents the next bit on CIPO, MSB first.
  - The first falling edge presents the data MSB.
- Write commit, at the nCS rising edge only. All of the following must hold:
  - count == FRAME_LEN
  - R/W = 1
  - addr < NUM_REGS
- When commit holds, the register, `wr_addr` and `wr_strobe` update together.
- When count ≠ FRAME_LEN and count > 0: pulse `frame_err`, no write.
- A write with addr ≥ NUM_REGS is silently ignored: no write, no error.
- A read never modifies any register. Read frames never commit, whatever their length.
- CIPO = 0 outside a read data phase.

## Timing
- Reset values:
  - every register = RESET_VAL
  - CIPO = 0, `cipo_oe` = 0
  - `wr_strobe` = 0, `wr_addr` = 0, `frame_err` = 0
  - FSM = DRAIN, so a frame already in progress at reset release is discarded
  - synchronisers are loaded with nCS = 1, SCLK = 0
- Reset asserted mid-frame: the frame is aborted with no write and no `frame_err`. After reset the block waits for nCS high before accepting a new frame.
- Input latency is 3 clk edges, pin to detected edge.
- Write visibility: `regs_out` and `wr_strobe` change at the 3rd clk edge after nCS is first sampled high. `wr_strobe` is high for exactly that one cycle.
- CIPO changes 3 clk edges after the SCLK pin falls.
- Requirements on the SPI master:
  - SCLK high and low phases each ≥ 4 clk periods.
  - nCS setup and hold to SCLK ≥ 4 clk periods.
- Simultaneous SCLK edge and nCS rise in the same cycle: the nCS rise takes priority and the SCLK edge is ignored.
- Back-to-back frames are allowed with nCS high for ≥ 4 clk periods.

## Test plan
Defaults: NUM_REGS = 8, ADDR_W = 7, DATA_W = 8, clk = 10× SCLK.
- Write 0x81,0xF0 (write, addr 1, data 0xF0) → reg1 = 0xF0; `wr_strobe` pulses once; `wr_addr` = 1; all other registers stay 0.
- After the previous write, read 0x01,0x00 → CIPO shifts out 0xF0 MSB first during bits 8–15; reg1 is still 0xF0.
- Write 0x90,0xAA (addr 0x10 ≥ NUM_REGS) → no register changes, no `wr_strobe`, no `frame_err`. Then read 0x10 → CIPO returns 0x00.
- 12-bit write frame, then nCS high → `frame_err` pulses once, no write. 17-bit frame → `frame_err` pulses at the 17th rising edge, no write, FSM in DRAIN until nCS high.
- Assert `rst_n` during bit 10 of write 0x83,0x55, then release while nCS stays low and the frame completes → reg3 = RESET_VAL, no `wr_strobe`. The next full write 0x83,0x55 → reg3 = 0x55.
- Two back-to-back writes, 0x82,0x11 then 0x82,0x22, with nCS high for 4 clk → `wr_strobe` pulses twice and reg2 ends at 0x22.

Source files
------------

// File: rtl/spi_regfile_rw.sv
// SPI slave register file with write and read-back, all logic in the clk domain.
// Frame: {rw, addr[ADDR_W], data[DATA_W]}, MSB first, SPI mode 0. Writes commit
// on the nCS rising edge; reads stream reg[addr] on CIPO during the data field.
module spi_regfile_rw #(
  parameter int                NUM_REGS  = 8,
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(1 + ADDR_W);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  // [0],[1] = 2-FF synchroniser, [2] = previous synced value for edge detect
  logic [2:0] sclk_q, ncs_q;
  logic [1:0] copi_q;
  // Fills with ones after reset; keeps DRAIN from trusting the reset-loaded nCS=1
  logic [1:0] fill_q;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]    shreg_q, shreg_d;
  logic [DATA_W-1:0]       out_sh_q;
  logic                    rd_q;
  logic                    cipo_q, strobe_q, ferr_q;
  logic [ADDR_W-1:0]       waddr_q;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];

  logic              sclk_rise, sclk_fall, ncs_rise;
  logic              fr_rw, hdr_rw;
  logic [ADDR_W-1:0] fr_addr, hdr_addr;
  logic [DATA_W-1:0] fr_data, rd_word;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < (ADDR_W+1)'(NUM_REGS));
  endfunction

  // Input synchronisers; reset to the idle bus state (nCS high, SCLK low)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= '0;
      ncs_q  <= '1;
      copi_q <= '0;
      fill_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SCLK};
      ncs_q  <= {ncs_q[1:0], nCS};
      copi_q <= {copi_q[0], COPI};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];

  assign shreg_d  = {shreg_q[FRAME_LEN-2:0], copi_q[1]};
  assign cnt_d    = cnt_q + CNT_W'(1);
  // Completed frame fields
  assign fr_rw    = shreg_q[FRAME_LEN-1];
  assign fr_addr  = shreg_q[DATA_W +: ADDR_W];
  assign fr_data  = shreg_q[DATA_W-1:0];
  // Header fields as they stand once the address field has just completed
  assign hdr_rw   = shreg_d[ADDR_W];
  assign hdr_addr = shreg_d[ADDR_W-1:0];

  // Read mux for the addressed register
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (hdr_addr == ADDR_W'(i)) rd_word = regs_q[i];
  end

  // Frame FSM, shifters, register file and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= DRAIN;
      cnt_q    <= '0;
      shreg_q  <= '0;
      out_sh_q <= '0;
      rd_q     <= 1'b0;
      cipo_q   <= 1'b0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      waddr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cipo_q <= 1'b0;
          rd_q   <= 1'b0;
          if (!ncs_q[1]) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          // nCS rise wins over any SCLK edge seen in the same cycle
          if (ncs_rise) begin
            state_q <= IDLE;
            cipo_q  <= 1'b0;
            rd_q    <= 1'b0;
            if (cnt_q == FRAME_CNT) begin
              if (fr_rw && in_range(fr_addr)) begin
                for (int i = 0; i < NUM_REGS; i++)
                  if (fr_addr == ADDR_W'(i)) regs_q[i] <= fr_data;
                waddr_q  <= fr_addr;
                strobe_q <= 1'b1;
              end
            end else if (cnt_q != '0) begin
              ferr_q <= 1'b1;
            end
          end else if (sclk_rise) begin
            if (cnt_q == FRAME_CNT) begin
              // Overrun: discard the rest of the frame
              ferr_q  <= 1'b1;
              cipo_q  <= 1'b0;
              rd_q    <= 1'b0;
              state_q <= DRAIN;
            end else begin
              shreg_q <= shreg_d;
              cnt_q   <= cnt_d;
              if (cnt_d == HDR_CNT && !hdr_rw) begin
                out_sh_q <= in_range(hdr_addr) ? rd_word : '0;
                rd_q     <= 1'b1;
              end
            end
          end else if (sclk_fall && rd_q) begin
            cipo_q   <= out_sh_q[DATA_W-1];
            out_sh_q <= out_sh_q << 1;
          end
        end
        DRAIN: begin
          cipo_q <= 1'b0;
          rd_q   <= 1'b0;
          if (ncs_q[1] && fill_q[1]) state_q <= IDLE;
        end
        default: state_q <= DRAIN;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign CIPO      = cipo_q;
  assign cipo_oe   = ~ncs_q[1];
  assign wr_strobe = strobe_q;
  assign wr_addr   = waddr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Scoreboard bench for spi_regfile_rw at default parameters, clk = 10x SCLK.
`timescale 1ns/1ps
module tb_spi_regfile_rw;

  localparam int NR = 8;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk, rst_n, SCLK, COPI, nCS;
  logic CIPO, cipo_oe, wr_strobe, frame_err;
  logic [NR*DW-1:0] regs_out;
  logic [AW-1:0]    wr_addr;

  spi_regfile_rw dut (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
    .CIPO(CIPO), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t             wr_q [$];
  logic [DW-1:0]   rd_q [$];
  logic [DW-1:0]   mdl [NR];
  int n_cmp = 0, n_bad = 0;
  int strobe_seen = 0, strobe_exp = 0;
  int ferr_seen = 0, ferr_exp = 0;
  logic oe_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  // Output monitor: pops expected writes as strobes appear, counts frame errors
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      wr_t e;
      strobe_seen++;
      if (wr_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.a));
        chk("wr_data", 64'(regs_out[int'(e.a)*DW +: DW]), 64'(e.d));
      end
    end
    if (frame_err === 1'b1) ferr_seen++;
  end

  // One SPI frame of nbits, MSB first; captures CIPO just before each rising edge.
  // rst_bit >= 0 pulses rst_n low across that bit.
  task automatic xfer(input int nbits, input logic [31:0] bits, input int rst_bit,
                      input int gap, output logic [31:0] cap, output int ferr_pre);
    cap = '0;
    nCS = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) rst_n = 1'b0;
      if (i == rst_bit + 1) rst_n = 1'b1;
      COPI = bits[nbits-1-i];
      #44;
      cap[nbits-1-i] = CIPO;
      if (i == 2) oe_seen = cipo_oe;
      #6;
      SCLK = 1'b1;
      #50;
      SCLK = 1'b0;
    end
    #44;
    ferr_pre = ferr_seen;
    #6;
    nCS = 1'b1;
    COPI = 1'b0;
    #(gap);
  endtask

  task automatic write_frame(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
    logic [31:0] cap;
    int fp;
    if (int'(a) < NR) begin
      wr_q.push_back('{a: a, d: d});
      mdl[a[2:0]] = d;
      strobe_exp++;
    end
    xfer(1+AW+DW, 32'({1'b1, a, d}), -1, gap, cap, fp);
    chk("wr_regs", 64'(regs_out), 64'(flat()));
    chk("wr_strobe_cnt", 64'(strobe_seen), 64'(strobe_exp));
    chk("wr_ferr_cnt", 64'(ferr_seen), 64'(ferr_exp));
  endtask

  task automatic read_frame(input logic [AW-1:0] a);
    logic [31:0] cap;
    logic [DW-1:0] e;
    int fp;
    rd_q.push_back(int'(a) < NR ? mdl[a[2:0]] : '0);
    xfer(1+AW+DW, 32'({1'b0, a, 8'h00}), -1, 80, cap, fp);
    e = rd_q.pop_front();
    chk("rd_data", 64'(cap[7:0]), 64'(e));
    chk("rd_cipo_hdr", 64'(cap[15:8]), 64'd0);
    chk("rd_cipo_oe", 64'(oe_seen), 64'd1);
    chk("rd_regs", 64'(regs_out), 64'(flat()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    int fp;
    rst_n = 1'b0; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #44;
    chk("rst_regs", 64'(regs_out), 64'd0);
    chk("rst_cipo", 64'(CIPO), 64'd0);
    chk("rst_oe", 64'(cipo_oe), 64'd0);
    chk("rst_strobe", 64'(wr_strobe), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    #56 rst_n = 1'b1;
    #100;

    // basic write then read-back
    write_frame(7'h01, 8'hF0, 80);
    read_frame(7'h01);

    // out-of-range write is silently dropped; out-of-range read returns zero
    write_frame(7'h10, 8'hAA, 80);
    read_frame(7'h10);

    // short frame: error on nCS rise, no write
    ferr_exp++;
    xfer(12, 32'hA5C, -1, 80, cap, fp);
    chk("short_ferr", 64'(ferr_seen), 64'(ferr_exp));
    chk("short_regs", 64'(regs_out), 64'(flat()));

    // overrun: error already at the 17th rising edge, none at nCS rise
    ferr_exp++;
    xfer(17, 32'h1_83AB, -1, 80, cap, fp);
    chk("ovr_ferr_pre", 64'(fp), 64'(ferr_exp));
    chk("ovr_ferr", 64'(ferr_seen), 64'(ferr_exp));
    chk("ovr_regs", 64'(regs_out), 64'(flat()));
    chk("ovr_strobe", 64'(strobe_seen), 64'(strobe_exp));

    // reset mid-frame: all regs back to reset value, frame discarded quietly
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    xfer(16, 32'h8355, 10, 80, cap, fp);
    chk("rstmid_regs", 64'(regs_out), 64'(flat()));
    chk("rstmid_strobe", 64'(strobe_seen), 64'(strobe_exp));
    chk("rstmid_ferr", 64'(ferr_seen), 64'(ferr_exp));
    write_frame(7'h03, 8'h55, 80);
    read_frame(7'h03);

    // back-to-back writes with minimal nCS high time
    write_frame(7'h02, 8'h11, 40);
    write_frame(7'h02, 8'h22, 80);

    chk("end_strobe_cnt", 64'(strobe_seen), 64'd4);
    chk("end_wr_q_empty", 64'(wr_q.size()), 64'd0);
    chk("end_reg2", 64'(regs_out[2*DW +: DW]), 64'h22);
    chk("end_ferr_cnt", 64'(ferr_seen), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
